// File: rtl/vc_multi_sat_counter.sv
// ---------------------------------------------------------------------------
// vc_multi_sat_counter
//   Bank of NUM_CH independent saturating up/down counters. Each channel takes
//   a multi-unit increment and decrement every cycle. When both arrive in the
//   same cycle they are netted against each other.
//   Each channel also has a synchronous load, plus sticky overflow/underflow
//   flags that are cleared per channel.
//
//   Optional feature macro: VC_MULTI_SAT_COUNTER_LOW_MARK_EN
//     defined   -> low[i] is a registered flag, (next count[i] <= LOW_MARK)
//     undefined -> low is tied to 0 and no watermark logic is built
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   inc_amt   in   per-channel increment, ch i at [i*STEP_WIDTH +: STEP_WIDTH]
//   dec_amt   in   per-channel decrement, packed like inc_amt
//   load      in   per-channel synchronous load strobe (beats inc/dec)
//   load_val  in   per-channel load value, ch i at [i*BIT_WIDTH +: BIT_WIDTH]
//   err_clr   in   per-channel clear of the sticky error flags
//   count     out  registered per-channel count
//   zero      out  count == 0 (decoded from the registered count)
//   full      out  count == MAX_COUNT (decoded from the registered count)
//   overflow  out  sticky: the channel saturated at the top
//   underflow out  sticky: the channel saturated at the bottom
//   low       out  low-watermark flag (0 unless the macro is defined)
// ---------------------------------------------------------------------------
module vc_multi_sat_counter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned BIT_WIDTH   = 4,
  parameter int unsigned MAX_COUNT   = 8,
  parameter int unsigned RESET_VALUE = 8,
  parameter int unsigned STEP_WIDTH  = 2,
  parameter int unsigned LOW_MARK    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*STEP_WIDTH-1:0] inc_amt,
  input  logic [NUM_CH*STEP_WIDTH-1:0] dec_amt,
  input  logic [NUM_CH-1:0]            load,
  input  logic [NUM_CH*BIT_WIDTH-1:0]  load_val,
  input  logic [NUM_CH-1:0]            err_clr,
  output logic [NUM_CH*BIT_WIDTH-1:0]  count,
  output logic [NUM_CH-1:0]            zero,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            overflow,
  output logic [NUM_CH-1:0]            underflow,
  output logic [NUM_CH-1:0]            low
);

  // Signed intermediate: two guard bits beyond count+step, so neither
  // count + inc nor the subsequent - dec can wrap.
  localparam int unsigned TW = BIT_WIDTH + STEP_WIDTH + 2;

  localparam logic [BIT_WIDTH-1:0]  MAX_C = BIT_WIDTH'(MAX_COUNT);
  localparam logic [BIT_WIDTH-1:0]  RST_C = BIT_WIDTH'(RESET_VALUE);
  localparam logic signed [TW-1:0]  MAX_T = $signed(TW'(MAX_COUNT));

  // Elaboration-time parameter legality.
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("vc_multi_sat_counter: NUM_CH must be >= 1");
  end
  if (MAX_COUNT >= (1 << BIT_WIDTH)) begin : g_bad_max
    $error("vc_multi_sat_counter: MAX_COUNT must be < 2**BIT_WIDTH");
  end
  if (RESET_VALUE > MAX_COUNT) begin : g_bad_rst
    $error("vc_multi_sat_counter: RESET_VALUE must be <= MAX_COUNT");
  end
  if (MAX_COUNT < 1) begin : g_bad_max_zero
    $error("vc_multi_sat_counter: MAX_COUNT must be >= 1");
  end
  // A watermark at or above the ceiling would make low permanently set.
  if (LOW_MARK >= MAX_COUNT) begin : g_odd_low_mark
    $warning("vc_multi_sat_counter: LOW_MARK >= MAX_COUNT, low is always set");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [STEP_WIDTH-1:0] inc_i;
    logic [STEP_WIDTH-1:0] dec_i;
    logic [BIT_WIDTH-1:0]  ld_i;
    logic [BIT_WIDTH-1:0]  cnt_q;
    logic [BIT_WIDTH-1:0]  cnt_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  udf_q;
    logic                  udf_d;
    logic                  set_ovf;
    logic                  set_udf;
    logic signed [TW-1:0]  t;

    assign inc_i = inc_amt[i*STEP_WIDTH +: STEP_WIDTH];
    assign dec_i = dec_amt[i*STEP_WIDTH +: STEP_WIDTH];
    assign ld_i  = load_val[i*BIT_WIDTH +: BIT_WIDTH];

    // Netted step, evaluated in a wide signed domain
    assign t = $signed(TW'(cnt_q)) + $signed(TW'(inc_i)) - $signed(TW'(dec_i));

    // Next-count selection: load beats step; the step saturates at both ends
    always_comb begin
      cnt_d   = cnt_q;
      set_ovf = 1'b0;
      set_udf = 1'b0;
      if (load[i]) begin
        if (ld_i > MAX_C) begin
          cnt_d   = MAX_C;
          set_ovf = 1'b1;
        end else begin
          cnt_d = ld_i;
        end
      end else if (t > MAX_T) begin
        cnt_d   = MAX_C;
        set_ovf = 1'b1;
      end else if (t[TW-1]) begin
        cnt_d   = '0;
        set_udf = 1'b1;
      end else begin
        cnt_d = BIT_WIDTH'(t);
      end
    end

    // Sticky flags: a set event in the same cycle as err_clr wins.
    always_comb begin
      ovf_d = set_ovf | (ovf_q & ~err_clr[i]);
      udf_d = set_udf | (udf_q & ~err_clr[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= RST_C;
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        udf_q <= udf_d;
      end
    end

    assign count[i*BIT_WIDTH +: BIT_WIDTH] = cnt_q;
    assign overflow[i]  = ovf_q;
    assign underflow[i] = udf_q;
    assign zero[i]      = (cnt_q == '0);
    assign full[i]      = (cnt_q == MAX_C);

`ifdef VC_MULTI_SAT_COUNTER_LOW_MARK_EN
    localparam logic [BIT_WIDTH-1:0] LOW_C = BIT_WIDTH'(LOW_MARK);
    logic low_q;

    // Registered from the next count so it moves together with count
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        low_q <= 1'b0;
      end else begin
        low_q <= (cnt_d <= LOW_C);
      end
    end

    assign low[i] = low_q;
`else
    assign low[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_vc_multi_sat_counter.sv
// ---------------------------------------------------------------------------
// tb_vc_multi_sat_counter
//   Directed table of per-cycle stimulus with hand-computed expected outputs
//   for the default parameter set, plus reset sequences. Channel i of every
//   packed field sits at the i-th lane (ch0 in the LSBs).
// ---------------------------------------------------------------------------
module tb_vc_multi_sat_counter;

  logic        clk;
  logic        reset;
  logic [7:0]  inc_amt;
  logic [7:0]  dec_amt;
  logic [3:0]  load;
  logic [15:0] load_val;
  logic [3:0]  err_clr;
  logic [15:0] count;
  logic [3:0]  zero;
  logic [3:0]  full;
  logic [3:0]  overflow;
  logic [3:0]  underflow;
  logic [3:0]  low;

  int n_tests;
  int n_fail;

  vc_multi_sat_counter dut (
    .clk       (clk),
    .reset     (reset),
    .inc_amt   (inc_amt),
    .dec_amt   (dec_amt),
    .load      (load),
    .load_val  (load_val),
    .err_clr   (err_clr),
    .count     (count),
    .zero      (zero),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .low       (low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  inc;
    logic [7:0]  dec;
    logic [3:0]  ld;
    logic [15:0] ld_val;
    logic [3:0]  clr;
    logic [15:0] e_count;
    logic [3:0]  e_zero;
    logic [3:0]  e_full;
    logic [3:0]  e_ovf;
    logic [3:0]  e_udf;
    logic [3:0]  e_low;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_count,
                           input logic [3:0] e_zero, input logic [3:0] e_full,
                           input logic [3:0] e_ovf, input logic [3:0] e_udf,
                           input logic [3:0] e_low);
    check({tag, " count"},     count,               e_count);
    check({tag, " zero"},      {12'h0, zero},       {12'h0, e_zero});
    check({tag, " full"},      {12'h0, full},       {12'h0, e_full});
    check({tag, " overflow"},  {12'h0, overflow},   {12'h0, e_ovf});
    check({tag, " underflow"}, {12'h0, underflow},  {12'h0, e_udf});
`ifdef VC_MULTI_SAT_COUNTER_LOW_MARK_EN
    check({tag, " low"},       {12'h0, low},        {12'h0, e_low});
`else
    if (e_low == e_low) check({tag, " low"}, {12'h0, low}, 16'h0000);
`endif
  endtask

  task automatic drive_idle();
    inc_amt  = '0;
    dec_amt  = '0;
    load     = '0;
    load_val = '0;
    err_clr  = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //              inc    dec    ld       ld_val    clr      count     zero     full     ovf      udf      low
    vecs[0]  = '{8'h3C, 8'h0F, 4'b0100, 16'h0F00, 4'b0000, 16'h8885, 4'b0000, 4'b1110, 4'b0100, 4'b0000, 4'b0000};
    vecs[1]  = '{8'h08, 8'hF7, 4'b0100, 16'h0400, 4'b0000, 16'h5482, 4'b0000, 4'b0010, 4'b0110, 4'b0000, 4'b0001};
    vecs[2]  = '{8'h00, 8'hC2, 4'b0000, 16'h0000, 4'b0010, 16'h2480, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b1001};
    vecs[3]  = '{8'h00, 8'hC1, 4'b0000, 16'h0000, 4'b1000, 16'h0480, 4'b1001, 4'b0010, 4'b0100, 4'b1001, 4'b1001};
    vecs[4]  = '{8'h00, 8'h00, 4'b0000, 16'h0000, 4'b1100, 16'h0480, 4'b1001, 4'b0010, 4'b0000, 4'b0001, 4'b1001};
    vecs[5]  = '{8'h00, 8'h00, 4'b0000, 16'h0000, 4'b0000, 16'h0480, 4'b1001, 4'b0010, 4'b0000, 4'b0001, 4'b1001};
    vecs[6]  = '{8'h33, 8'h10, 4'b0000, 16'h0000, 4'b0000, 16'h0683, 4'b1000, 4'b0010, 4'b0000, 4'b0001, 4'b1000};
    vecs[7]  = '{8'h00, 8'h00, 4'b1011, 16'h9008, 4'b0001, 16'h8608, 4'b0010, 4'b1001, 4'b1000, 4'b0000, 4'b0010};
    vecs[8]  = '{8'h0C, 8'h03, 4'b0000, 16'h0000, 4'b0000, 16'h8635, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    vecs[9]  = '{8'h00, 8'h03, 4'b0000, 16'h0000, 4'b0000, 16'h8632, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    vecs[10] = '{8'h01, 8'h00, 4'b0000, 16'h0000, 4'b0000, 16'h8633, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};

    // Power-on reset with a nonzero step pending
    drive_idle();
    inc_amt = 8'hFF;
    reset   = 1'b0;
    #12;
    check_all("reset", 16'h8888, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    check_all("post-reset hold", 16'h8888, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    // Table: drive on the falling edge, sample on the next falling edge
    for (int k = 0; k < NV; k++) begin
      inc_amt  = vecs[k].inc;
      dec_amt  = vecs[k].dec;
      load     = vecs[k].ld;
      load_val = vecs[k].ld_val;
      err_clr  = vecs[k].clr;
      @(negedge clk);
      check_all($sformatf("v%0d", k), vecs[k].e_count, vecs[k].e_zero,
                vecs[k].e_full, vecs[k].e_ovf, vecs[k].e_udf, vecs[k].e_low);
    end

    // Asynchronous reset mid-cycle with an in-flight load and step
    inc_amt  = 8'hFF;
    dec_amt  = 8'h00;
    load     = 4'b0010;
    load_val = 16'h0010;
    #2;
    reset = 1'b0;
    #1;
    check_all("async reset", 16'h8888, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    check_all("reset held over edge", 16'h8888, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    check_all("release hold", 16'h8888, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    // First step after release is honoured
    dec_amt = 8'h40;
    @(negedge clk);
    drive_idle();
    check_all("first step", 16'h7888, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vc_multi_sat_counter.md
Name: vc_multi_sat_counter

Overview:
- Parametrised, multi-channel saturating up/down counter bank.
- Successor to the single-channel ±1 counter. Adds:
  - N independent channels.
  - Multi-unit increment and decrement steps per cycle, netted when both arrive together.
  - Per-channel synchronous load.
  - Sticky overflow/underflow error flags.
- Used for per-queue credit tracking and outstanding-request accounting in multi-port memory and network blocks.

Parameters:
- NUM_CH, 4, number of independent counter channels (>=1).
- BIT_WIDTH, 4, width of each channel's count.
- MAX_COUNT, 8, saturation ceiling. Must be < 2**BIT_WIDTH.
- RESET_VALUE, 8, count value after reset. Must be <= MAX_COUNT.
- STEP_WIDTH, 2, width of each per-channel increment/decrement amount. Maximum step is 2**STEP_WIDTH-1.
- LOW_MARK, 2, low-watermark threshold. Used only when the optional feature is enabled.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- inc_amt  in  NUM_CH*STEP_WIDTH  per-channel increment amount. Channel i occupies bits [i*STEP_WIDTH +: STEP_WIDTH].
- dec_amt  in  NUM_CH*STEP_WIDTH  per-channel decrement amount, packed the same way.
- load  in  NUM_CH  per-channel synchronous load strobe.
- load_val  in  NUM_CH*BIT_WIDTH  per-channel load value.
- err_clr  in  NUM_CH  per-channel clear of the sticky error flags.
- count  out  NUM_CH*BIT_WIDTH  registered per-channel count.
- zero  out  NUM_CH  count==0, per channel.
- full  out  NUM_CH  count==MAX_COUNT, per channel.
- overflow  out  NUM_CH  sticky: a saturation at the top occurred.
- underflow  out  NUM_CH  sticky: a saturation at the bottom occurred.
- low  out  NUM_CH  low-watermark indication (see Optional Feature).

Behaviour:
- Reset:
  - reset low asynchronously forces every count to RESET_VALUE.
  - overflow, underflow and low go to 0.
  - zero and full follow the reset count.
  - Deassertion takes effect at the next rising clk edge.
- Channels are fully independent. No cross-channel interaction.
- Per channel, per cycle, next count is chosen in priority order:
  - load=1: next = min(load_val, MAX_COUNT). inc_amt and dec_amt are ignored. Overflow/underflow are not updated by the step.
  - Otherwise: compute t = count + inc_amt - dec_amt in a signed intermediate of BIT_WIDTH+STEP_WIDTH+2 bits. No wrap-around is permitted at any stage.
    - t > MAX_COUNT: next = MAX_COUNT, set overflow.
    - t < 0: next = 0, set underflow.
    - Otherwise: next = t.
- Simultaneous increment and decrement are netted. Example: count=8, inc=3, dec=3 gives next=8 with no overflow, because the net change is 0.
- A load_val above MAX_COUNT clamps to MAX_COUNT and sets overflow.
- Sticky flags:
  - Once set, a flag holds until err_clr=1 for that channel.
  - If err_clr and a new set event occur in the same cycle, set wins and the flag stays 1.
- Latency:
  - count, overflow and underflow update one cycle after the stimulus edge.
  - zero and full are combinational decodes of the registered count.
  - zero and full are never asserted together, because MAX_COUNT >= 1.
- Zero amounts (inc=dec=0, load=0) hold count exactly.
- Reset mid-operation: the asynchronous assertion overrides any in-flight load or step. That cycle's update is lost.
- Parameter legality (MAX_COUNT < 2**BIT_WIDTH, RESET_VALUE <= MAX_COUNT) is checked at elaboration. A violation triggers $error under simulation.

Optional Feature:
- Macro: VC_MULTI_SAT_COUNTER_LOW_MARK_EN.
- Defined:
  - low[i] is a registered flag equal to (next count[i] <= LOW_MARK).
  - It therefore changes in the same cycle as count.
  - It resets to 0, then updates from the first clocked count onward.
- Undefined: low is tied to 0 and no watermark logic is built. All other behaviour is identical.

Test Plan:
(All scenarios use defaults: NUM_CH=4, BIT_WIDTH=4, MAX_COUNT=8, RESET_VALUE=8, STEP_WIDTH=2.)
- Reset: assert reset=0 mid-cycle with inc_amt nonzero -> count immediately reads 8 on all channels, full=4'hF, zero=0, flags 0; release -> counts hold at 8.
- Ch0 dec 3,3,2 over three cycles -> count 5,2,0; zero[0]=1 after third; then dec 1 -> count stays 0, underflow[0]=1; other channels unchanged.
- Ch1 from 8: inc=3 and dec=3 same cycle -> count 8, overflow[1]=0. Then inc=2, dec=1 -> count 8, overflow[1]=1. err_clr[1] alone -> overflow[1]=0.
- Ch2 load=1, load_val=15, inc=3 -> count 8, overflow[2]=1. Next load_val=4 with dec=3 -> count 4 (dec ignored).
- Ch3 err_clr=1 in the same cycle as an underflow event -> underflow[3] remains 1. Next cycle with err_clr=1 and no event -> 0.
- With VC_MULTI_SAT_COUNTER_LOW_MARK_EN: ch0 dec from 8 by 3,3 -> low[0]=0 at count 5, 1 at count 2. Inc 1 -> count 3, low[0]=0. Without the macro, low stays 0 throughout.
